// File: rtl/dtc_dout_framer.sv
`default_nettype none
// ============================================================================
// Module   : dtc_dout_framer
// Purpose  : Slot-aligned byte framer (IDLE fill / SOF / escaped payload / EOF)
//            feeding the DTC output serializer and owning its reset.
// Revision : 1.0 - initial release
// ============================================================================
module dtc_dout_framer #(
    parameter logic [7:0] IDLE_BYTE = 8'h55,
    parameter logic [7:0] SOF_BYTE  = 8'hBC,
    parameter logic [7:0] EOF_BYTE  = 8'hFD,
    parameter logic [7:0] ESC_BYTE  = 8'h7D
) (
    input  logic        bitclk,
    input  logic        reset_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  dtc_pdin,
    output logic        ser_reset,
    output logic        busy,
    output logic        underrun,
    output logic [15:0] frame_cnt
);

    localparam logic [7:0] c_ESC_MASK = 8'h20;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_ESC2 = 2'd2,
        S_EOF  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_ser_reset;
    logic [2:0]  r_slot_cnt;
    logic        w_slot_end;

    logic        r_hold_vld;
    logic [7:0]  r_hold_data;
    logic        r_hold_last;
    logic        w_in_ready;
    logic        w_accept;
    logic        w_hold_special;

    logic [7:0]  r_dtc_pdin;
    logic        r_underrun;
    logic [15:0] r_frame_cnt;

    logic [7:0]  w_sym;
    logic        w_consume;
    logic        w_underrun;
    logic        w_frame_done;

    // Slot counter runs in lockstep with the serializer bit counter: both are
    // held by ser_reset and released on the same edge.
    always_ff @(posedge bitclk or negedge reset_n) begin
        if (!reset_n) begin
            r_ser_reset <= 1'b1;
            r_slot_cnt  <= 3'd0;
        end else begin
            r_ser_reset <= 1'b0;
            r_slot_cnt  <= r_ser_reset ? 3'd0 : r_slot_cnt + 3'd1;
        end
    end

    assign w_slot_end = (r_slot_cnt == 3'd7) & ~r_ser_reset;

    assign w_in_ready = ~r_hold_vld & ~r_ser_reset;
    assign w_accept   = in_valid & w_in_ready;

    always_ff @(posedge bitclk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_vld  <= 1'b0;
            r_hold_data <= 8'h00;
            r_hold_last <= 1'b0;
        end else if (w_accept) begin
            r_hold_vld  <= 1'b1;
            r_hold_data <= in_data;
            r_hold_last <= in_last;
        end else if (w_slot_end && w_consume) begin
            r_hold_vld  <= 1'b0;
        end
    end

    assign w_hold_special = (r_hold_data == SOF_BYTE) || (r_hold_data == EOF_BYTE) ||
                            (r_hold_data == ESC_BYTE) || (r_hold_data == IDLE_BYTE);

    always_ff @(posedge bitclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else if (w_slot_end) begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and slot symbol; only take effect on slot_end.
    always_comb begin
        w_state_nxt  = r_state;
        w_sym        = IDLE_BYTE;
        w_consume    = 1'b0;
        w_underrun   = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_hold_vld) begin
                    w_sym       = SOF_BYTE;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (!r_hold_vld) begin
                    w_underrun = 1'b1;
                end else if (w_hold_special) begin
                    w_sym       = ESC_BYTE;
                    w_state_nxt = S_ESC2;
                end else begin
                    w_sym       = r_hold_data;
                    w_consume   = 1'b1;
                    w_state_nxt = r_hold_last ? S_EOF : S_DATA;
                end
            end
            S_ESC2: begin
                w_sym       = r_hold_data ^ c_ESC_MASK;
                w_consume   = 1'b1;
                w_state_nxt = r_hold_last ? S_EOF : S_DATA;
            end
            S_EOF: begin
                w_sym        = EOF_BYTE;
                w_frame_done = 1'b1;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge bitclk or negedge reset_n) begin
        if (!reset_n) begin
            r_dtc_pdin  <= IDLE_BYTE;
            r_underrun  <= 1'b0;
            r_frame_cnt <= 16'd0;
        end else begin
            r_underrun <= w_slot_end & w_underrun;
            if (w_slot_end) begin
                r_dtc_pdin <= w_sym;
                if (w_frame_done) begin
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign dtc_pdin  = r_dtc_pdin;
    assign ser_reset = r_ser_reset;
    assign busy      = (r_state != S_IDLE);
    assign underrun  = r_underrun;
    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dtc_dout_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dtc_dout_framer
// Purpose  : Scoreboard bench for dtc_dout_framer with a serializer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dtc_dout_framer;

    localparam logic [2:0] K_SOF = 3'd0;
    localparam logic [2:0] K_DAT = 3'd1;
    localparam logic [2:0] K_ESC = 3'd2;
    localparam logic [2:0] K_EOF = 3'd3;
    localparam logic [2:0] K_UND = 3'd4;

    typedef struct {
        logic [7:0] sym;
        logic [2:0] kind;
    } exp_t;

    logic        bitclk;
    logic        reset_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [7:0]  dtc_pdin;
    logic        ser_reset;
    logic        busy;
    logic        underrun;
    logic [15:0] frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic        in_frame   = 1'b0;
    int          gap_idles  = 0;
    int          last_gap   = -1;
    int          und_seen   = 0;
    logic        prev_und   = 1'b0;
    logic [7:0]  prev_pdin  = 8'h55;
    logic [15:0] exp_frames = 16'd0;

    // Serializer model: bit counter and MSB-first shift register.
    logic [2:0]  bc   = 3'd0;
    logic [7:0]  sh   = 8'h00;
    logic        strb = 1'b0;
    logic        line;

    dtc_dout_framer dut (
        .bitclk    (bitclk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .dtc_pdin  (dtc_pdin),
        .ser_reset (ser_reset),
        .busy      (busy),
        .underrun  (underrun),
        .frame_cnt (frame_cnt)
    );

    initial bitclk = 1'b0;
    always #5 bitclk = ~bitclk;

    assign line = sh[7];

    always @(posedge bitclk) begin
        if (ser_reset) begin
            bc   <= 3'd0;
            sh   <= 8'h00;
            strb <= 1'b0;
        end else begin
            bc   <= bc + 3'd1;
            strb <= (bc == 3'd7);
            sh   <= (bc == 3'd0) ? dtc_pdin : {sh[6:0], 1'b0};
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic is_special(input logic [7:0] d);
        return (d == 8'hBC) || (d == 8'hFD) || (d == 8'h7D) || (d == 8'h55);
    endfunction

    task automatic push_exp(input logic [7:0] s, input logic [2:0] k);
        exp_t e;
        e.sym  = s;
        e.kind = k;
        exp_q.push_back(e);
    endtask

    // Symbol monitor: one symbol per slot, compared against the scoreboard.
    always @(negedge bitclk) begin
        if (!reset_n) begin
            exp_q.delete();
            in_frame   = 1'b0;
            exp_frames = 16'd0;
            gap_idles  = 0;
            prev_pdin  = dtc_pdin;
            prev_und   = 1'b0;
        end else begin
            if (dtc_pdin != prev_pdin)
                check_eq("sym_phase", {31'd0, strb}, 32'd1);
            prev_pdin = dtc_pdin;
            if (underrun) begin
                und_seen++;
                check_eq("underrun_width", {31'd0, prev_und}, 32'd0);
            end
            prev_und = underrun;
            if (strb) begin
                if (!in_frame && dtc_pdin == 8'h55) begin
                    gap_idles++;
                end else if (exp_q.size() == 0) begin
                    check_eq("sym_extra", {24'd0, dtc_pdin}, 32'h55);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("sym", {24'd0, dtc_pdin}, {24'd0, mon_e.sym});
                    check_eq("underrun", {31'd0, underrun}, {31'd0, mon_e.kind == K_UND});
                    check_eq("busy", {31'd0, busy}, {31'd0, mon_e.kind != K_EOF});
                    if (mon_e.kind == K_DAT)
                        check_eq("rdy_after_consume", {31'd0, in_ready}, 32'd1);
                    if (mon_e.kind == K_SOF) begin
                        in_frame = 1'b1;
                        last_gap = gap_idles;
                    end
                    if (mon_e.kind == K_EOF) begin
                        in_frame   = 1'b0;
                        gap_idles  = 0;
                        exp_frames = exp_frames + 16'd1;
                        check_eq("frame_cnt", {16'd0, frame_cnt}, {16'd0, exp_frames});
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic l, input logic f);
        int n;
        if (f) push_exp(8'hBC, K_SOF);
        if (is_special(d)) begin
            push_exp(8'h7D, K_ESC);
            push_exp(d ^ 8'h20, K_DAT);
        end else begin
            push_exp(d, K_DAT);
        end
        if (l) push_exp(8'hFD, K_EOF);
        @(negedge bitclk);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = l;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge bitclk);
            n++;
        end
        if (!in_ready) check_eq("send_tmo", {31'd0, in_ready}, 32'd1);
        @(posedge bitclk);
    endtask

    task automatic drop_src();
        @(negedge bitclk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_strobes(input int cnt);
        int n;
        int k;
        n = 0;
        k = 0;
        while (k < cnt && n < 500) begin
            @(negedge bitclk);
            if (strb) k++;
            n++;
        end
        if (k < cnt) check_eq("strobe_tmo", k, cnt);
    endtask

    task automatic wait_sym(input logic [7:0] s);
        int n;
        n = 0;
        do begin
            @(negedge bitclk);
            n++;
        end while (!(strb && dtc_pdin == s) && n < 300);
        if (!(strb && dtc_pdin == s)) check_eq("wait_sym_tmo", {24'd0, dtc_pdin}, {24'd0, s});
    endtask

    task automatic wait_drained();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_frame) && n < 1000) begin
            @(negedge bitclk);
            n++;
        end
        check_eq("drain", exp_q.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int und_before;
        logic prev_line;
        reset_n  = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        in_last  = 1'b0;

        // 1: reset state, release, idle fill and serial pattern
        repeat (3) @(negedge bitclk);
        check_eq("rst_pdin",      {24'd0, dtc_pdin}, 32'h55);
        check_eq("rst_ser_reset", {31'd0, ser_reset}, 32'd1);
        check_eq("rst_in_ready",  {31'd0, in_ready}, 32'd0);
        check_eq("rst_busy",      {31'd0, busy}, 32'd0);
        check_eq("rst_underrun",  {31'd0, underrun}, 32'd0);
        check_eq("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        reset_n = 1'b1;
        @(negedge bitclk);
        check_eq("ser_reset_rel", {31'd0, ser_reset}, 32'd0);
        check_eq("in_ready_rel",  {31'd0, in_ready}, 32'd1);
        repeat (20) @(negedge bitclk);
        check_eq("idle_pdin", {24'd0, dtc_pdin}, 32'h55);
        prev_line = line;
        for (int i = 0; i < 8; i++) begin
            @(negedge bitclk);
            check_eq("line_toggle", {31'd0, line}, {31'd0, ~prev_line});
            prev_line = line;
        end

        // 2: simple two-byte frame
        send_byte(8'h12, 1'b0, 1'b1);
        send_byte(8'h34, 1'b1, 1'b0);
        drop_src();
        wait_drained();
        wait_strobes(2);
        check_eq("frame_cnt_t2", {16'd0, frame_cnt}, 32'd1);
        check_eq("idle_after_eof", {31'd0, gap_idles > 0}, 32'd1);

        // 3: escaped payload
        send_byte(8'h7D, 1'b0, 1'b1);
        send_byte(8'hBC, 1'b0, 1'b0);
        send_byte(8'h55, 1'b1, 1'b0);
        drop_src();
        wait_drained();

        // 4: two-slot underrun mid-frame
        und_before = und_seen;
        send_byte(8'hAA, 1'b0, 1'b1);
        drop_src();
        push_exp(8'h55, K_UND);
        push_exp(8'h55, K_UND);
        wait_sym(8'hAA);
        wait_strobes(2);
        send_byte(8'hBB, 1'b1, 1'b0);
        drop_src();
        wait_drained();
        check_eq("underrun_cnt", und_seen - und_before, 2);

        // 5: back-to-back one-byte frames, source always valid
        send_byte(8'h01, 1'b1, 1'b1);
        send_byte(8'h02, 1'b1, 1'b1);
        drop_src();
        wait_drained();
        check_eq("b2b_gap", last_gap, 0);
        check_eq("frame_cnt_t5", {16'd0, frame_cnt}, 32'd5);

        // 6: asynchronous reset while in ESC2
        send_byte(8'h7D, 1'b0, 1'b1);
        drop_src();
        wait_sym(8'h7D);
        @(negedge bitclk);
        #2 reset_n = 1'b0;
        #1;
        check_eq("arst_pdin",      {24'd0, dtc_pdin}, 32'h55);
        check_eq("arst_ser_reset", {31'd0, ser_reset}, 32'd1);
        check_eq("arst_busy",      {31'd0, busy}, 32'd0);
        check_eq("arst_in_ready",  {31'd0, in_ready}, 32'd0);
        check_eq("arst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        repeat (3) @(negedge bitclk);
        reset_n = 1'b1;
        @(negedge bitclk);
        check_eq("ser_reset_rel2", {31'd0, ser_reset}, 32'd0);
        check_eq("hold_cleared",   {31'd0, in_ready}, 32'd1);
        wait_strobes(3);
        check_eq("fill_after_rst", {24'd0, dtc_pdin}, 32'h55);
        check_eq("frame_cnt_t6",   {16'd0, frame_cnt}, 32'd0);
        send_byte(8'h5A, 1'b1, 1'b1);
        drop_src();
        wait_drained();
        check_eq("frame_cnt_post", {16'd0, frame_cnt}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
